// File: rtl/data_memory_if.sv
// Bus bundle for the MIPS data memory: shared address, write data/enable and registered read data.
// parity_err exists only when DMEM_PARITY_EN is defined.
interface data_memory_if #(
    parameter int unsigned DATA_IN_SZ  = 32,
    parameter int unsigned DATA_OUT_SZ = 32,
    parameter int unsigned ADDRESS_SZ  = 10
);
    logic [DATA_IN_SZ-1:0]  data_in;
    logic [ADDRESS_SZ-1:0]  address;
    logic                   we;
    logic [DATA_OUT_SZ-1:0] data_out;
`ifdef DMEM_PARITY_EN
    logic                   parity_err;

    modport master (output data_in, address, we, input data_out, parity_err);
    modport slave  (input data_in, address, we, output data_out, parity_err);
`else
    modport master (output data_in, address, we, input data_out);
    modport slave  (input data_in, address, we, output data_out);
`endif
endinterface

// File: rtl/data_memory.sv
// Single-port word-addressed data RAM: synchronous write, registered write-first read.
// Optional even-parity protection per word when DMEM_PARITY_EN is defined.
module data_memory #(
    parameter int unsigned DATA_IN_SZ  = 32,
    parameter int unsigned DATA_OUT_SZ = 32,
    parameter int unsigned ADDRESS_SZ  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    data_memory_if.slave  bus
);
    localparam int unsigned Depth = 2 ** ADDRESS_SZ;
`ifdef DMEM_PARITY_EN
    localparam int unsigned WordSz = DATA_IN_SZ + 1;
`else
    localparam int unsigned WordSz = DATA_IN_SZ;
`endif

    logic [WordSz-1:0]      mem [Depth];
    logic [WordSz-1:0]      wr_word;
    logic [WordSz-1:0]      rd_word;
    logic                   wr_en;
    logic [DATA_OUT_SZ-1:0] data_out_d, data_out_q;
`ifdef DMEM_PARITY_EN
    logic                   parity_err_d, parity_err_q;
`endif

    always_comb begin
        wr_en = bus.we & rst_n;
`ifdef DMEM_PARITY_EN
        wr_word = {^bus.data_in, bus.data_in};
`else
        wr_word = bus.data_in;
`endif
        // Write-first: a same-address write bypasses the array onto the read path.
        rd_word    = bus.we ? wr_word : mem[bus.address];
        data_out_d = DATA_OUT_SZ'(rd_word[DATA_IN_SZ-1:0]);
`ifdef DMEM_PARITY_EN
        // XOR over data plus stored parity bit is 1 exactly when they disagree.
        parity_err_d = ^rd_word;
`endif
    end

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.address] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

`ifdef DMEM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.parity_err = parity_err_q;
`endif

    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; parity steps run when DMEM_PARITY_EN is defined.
module tb_data_memory;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    data_memory_if #(.DATA_IN_SZ(32), .DATA_OUT_SZ(32), .ADDRESS_SZ(10)) bus ();

    data_memory #(.DATA_IN_SZ(32), .DATA_OUT_SZ(32), .ADDRESS_SZ(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [9:0] a, input logic [31:0] d);
        bus.we      = w;
        bus.address = a;
        bus.data_in = d;
    endtask

    initial begin
        drive(1'b1, 10'd5, 32'h0000_DEAD);
        #1;
        check("reset_t0", bus.data_out, 32'h0);
`ifdef DMEM_PARITY_EN
        check("reset_par", {31'b0, bus.parity_err}, 32'h0);
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", bus.data_out, 32'h0);
        end

        // Release between edges; the blocked write must not have landed.
        #2;
        rst_n = 1'b1;
        drive(1'b0, 10'd5, 32'h0);
        step();
        n_vec++;
        assert (bus.data_out !== 32'h0000_DEAD) else begin
            n_bad++;
            $error("FAIL reset_nowrite: observed %h expected not %h", bus.data_out, 32'h0000_DEAD);
        end

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 10'(i), 32'(i * 2));
            step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 10'(i), 32'h0);
            step();
            check("seq_read", bus.data_out, 32'(i * 2));
        end

        drive(1'b1, 10'd7, 32'h0BAD_F00D);
        step();
        drive(1'b1, 10'd7, 32'h1234_5678);
        step();
        check("rdw_first", bus.data_out, 32'h1234_5678);
        drive(1'b0, 10'd7, 32'h0);
        step();
        check("rdw_stored", bus.data_out, 32'h1234_5678);

        drive(1'b1, 10'd512, 32'h5A5A_0512);
        step();
        drive(1'b1, 10'd0, 32'hFFFF_FFFF);
        step();
        drive(1'b1, 10'd1023, 32'hA5A5_A5A5);
        step();
        drive(1'b0, 10'd0, 32'h0);
        step();
        check("bound_lo", bus.data_out, 32'hFFFF_FFFF);
        drive(1'b0, 10'd1023, 32'h0);
        step();
        check("bound_hi", bus.data_out, 32'hA5A5_A5A5);
        drive(1'b0, 10'd512, 32'h0);
        step();
        check("bound_mid", bus.data_out, 32'h5A5A_0512);

        drive(1'b1, 10'd3, 32'h0000_0055);
        step();
        drive(1'b0, 10'd3, 32'h0);
        step();
        check("mid_pre", bus.data_out, 32'h0000_0055);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async", bus.data_out, 32'h0);
        drive(1'b1, 10'd3, 32'h0000_0BAD);
        step();
        check("mid_hold", bus.data_out, 32'h0);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 10'd3, 32'h0);
        step();
        check("mid_retain", bus.data_out, 32'h0000_0055);

`ifdef DMEM_PARITY_EN
        drive(1'b1, 10'd9, 32'h0000_0007);
        step();
        check("par_rdw", {31'b0, bus.parity_err}, 32'h0);
        drive(1'b0, 10'd9, 32'h0);
        step();
        check("par_clean", {31'b0, bus.parity_err}, 32'h0);
        dut.mem[9][0] = ~dut.mem[9][0];
        step();
        check("par_flip_err", {31'b0, bus.parity_err}, 32'h1);
        check("par_flip_data", bus.data_out, 32'h0000_0006);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Single-port synchronous word-addressed RAM used as the MIPS data memory, between the ALU/address path and the writeback mux.
- One write port and one read port share a single address bus.
- Writes commit on the rising clock edge; reads are registered with 1-cycle latency.

Parameters:
- DATA_IN_SZ, 32, width of a stored word and of data_in.
- DATA_OUT_SZ, 32, width of data_out.
  - If narrower than DATA_IN_SZ, data_out carries the low DATA_OUT_SZ bits of the word.
  - If wider, the word is zero-extended.
- ADDRESS_SZ, 10, address width; depth = 2**ADDRESS_SZ words (1024 by default).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_IN_SZ  write data.
- address  input  ADDRESS_SZ  word address for both read and write.
- we  input  1  write enable, active high.
- data_out  output  DATA_OUT_SZ  registered read data.
- parity_err  output  1  present only with DMEM_PARITY_EN.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low immediately forces data_out to 0, independent of clk.
  - data_out stays 0 while rst_n is low.
  - Memory array contents are not cleared by reset.
  - Writes are blocked while rst_n is low.
- Write: at posedge clk with rst_n high and we=1, mem[address] <= data_in.
- Read:
  - At every posedge clk with rst_n high, data_out <= mem[address] (width-adjusted per DATA_OUT_SZ).
  - The read fires regardless of we.
  - Latency: data appears 1 cycle after the edge that samples address.
- Read-during-write, same address: write-first. data_out at that edge takes the new data_in value, not the old contents.
- Addressing: full 2**ADDRESS_SZ range valid; there is no out-of-range case and no wrap logic.
- Uninitialised words read as X in simulation. Synthesis must not add reset logic to the array.
- Reset release: the first edge after rst_n rises performs a normal read/write.
- Reset mid-operation: a write whose edge coincides with rst_n low is discarded.
- The array must infer as block RAM: no asynchronous reads of the array and no per-word reset.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from data_in on write.
  - On read, parity is recomputed over the stored word.
  - parity_err is registered alongside data_out and is 1 when stored and recomputed parity differ.
  - parity_err resets to 0.
  - A same-address write-first read reports parity_err=0.
  - Words never written may report X.
- Not defined: the parity_err port and the parity storage do not exist; the port list is exactly as above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with we=1, address=5, data_in=32'hDEAD -> data_out=0 throughout. After release with we=0, a read of address 5 is not 32'hDEAD.
- Sequential write/readback:
  - Write i*2 to addresses 0..4 (we=1, one write per cycle).
  - Then set we=0 and read 0..4.
  - Expected: data_out = 0,2,4,6,8, each one cycle after its address is presented.
- Read-during-write: we=1, address=7, data_in=32'h1234_5678 -> data_out=32'h1234_5678 after that same edge (write-first).
- Boundary addresses:
  - Write 32'hFFFF_FFFF to address 0 and 32'hA5A5_A5A5 to address 1023.
  - Read both back.
  - Expected: exact values, and address 512 is unaffected.
- Async reset mid-stream:
  - Write 32'h55 to address 3.
  - Pulse rst_n low between edges -> data_out drops to 0 immediately.
  - After release, a read of address 3 returns 32'h55 (array retained).
- Parity (DMEM_PARITY_EN): write 32'h0000_0007 to address 9, read back -> parity_err=0. Force-flip one stored bit via hierarchical access, read -> parity_err=1.
